// File: rtl/ex_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_unit_pkg
//   Shared definitions for the EX-stage iterative divider.
//   - DIV_WIDTH   : default operand width
//   - div_state_e : 2-bit FSM encoding (FREE / DZERO / ON / END)
//   - div_busy()  : states in which the divider holds the EX instruction
// ---------------------------------------------------------------------------
package ex_div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE  = 2'b00,
    DIV_DZERO = 2'b01,
    DIV_ON    = 2'b10,
    DIV_END   = 2'b11
  } div_state_e;

  // A divide in flight (iterating or reporting divide-by-zero) keeps EX stalled.
  function automatic logic div_busy(input div_state_e s);
    return (s == DIV_ON) || (s == DIV_DZERO);
  endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step.
//   Ports:
//     rem      in  WIDTH  partial remainder (always < divisor)
//     dq       in  WIDTH  dividend bits still to consume (MSB first) with
//                         quotient bits collected in the low end
//     divisor  in  WIDTH  divisor magnitude
//     rem_next out WIDTH  partial remainder after this step
//     dq_next  out WIDTH  dq shifted left by one with the new quotient bit
// ---------------------------------------------------------------------------
module div_step
  import ex_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dq_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Bring down the next dividend bit; the subtract is one bit wider than the
  // operands so its MSB is the borrow.
  assign shifted = {rem, dq[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = trial[WIDTH-1:0];
    dq_next  = {dq[WIDTH-2:0], 1'b1};
    if (trial[WIDTH]) begin
      // Borrow: restore. Since rem < divisor, the shifted value fits WIDTH bits.
      rem_next = shifted[WIDTH-1:0];
      dq_next  = {dq[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// ---------------------------------------------------------------------------
// ex_div_unit
//   Iterative radix-2 integer divider for DIV/DIVU/REM/REMU in the EX stage.
//   Signed operands are reduced to magnitudes, divided WIDTH restore steps,
//   then sign-corrected. The EX instruction is held via stallreq_o.
//   Ports:
//     clk         in   1        pipeline clock, rising edge
//     rst         in   1        asynchronous reset, active low
//     start_i     in   1        EX holds a divide op (level)
//     signed_i    in   1        1 = signed divide
//     dividend_i  in   WIDTH    operand A, sampled on accept only
//     divisor_i   in   WIDTH    operand B, sampled on accept only
//     annul_i     in   1        flush/cancel of the EX instruction
//     result_o    out  2*WIDTH  {remainder, quotient}, zero unless ready_o
//     ready_o     out  1        one-cycle result-valid pulse
//     stallreq_o  out  1        stall request to the pipeline controller
//   Latency: accept in cycle 0, WIDTH ON cycles, ready in cycle WIDTH+1.
//   Divide by zero is ready in cycle 2.
// ---------------------------------------------------------------------------
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_e         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   dq_reg;
  logic [WIDTH-1:0]   dvsr_reg;
  logic               qneg_reg;
  logic               rneg_reg;
  logic               ready_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_zero;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   dq_step;
  logic [WIDTH-1:0]   q_fixed;
  logic [WIDTH-1:0]   r_fixed;

  // Operand magnitudes. The magnitude of MIN is 2^(WIDTH-1), which is exact
  // as an unsigned WIDTH-bit value, so MIN/-1 needs no special case.
  assign a_neg    = signed_i & dividend_i[WIDTH-1];
  assign b_neg    = signed_i & divisor_i[WIDTH-1];
  assign a_mag    = a_neg ? -dividend_i : dividend_i;
  assign b_mag    = b_neg ? -divisor_i  : divisor_i;
  assign div_zero = (divisor_i == '0);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_reg),
    .dq       (dq_reg),
    .divisor  (dvsr_reg),
    .rem_next (rem_step),
    .dq_next  (dq_step)
  );

  // Sign correction applied to the outcome of the final step.
  assign q_fixed = qneg_reg ? -dq_step  : dq_step;
  assign r_fixed = rneg_reg ? -rem_step : rem_step;

  // An annulled instruction must not stall the pipeline in its flush cycle.
  assign stallreq_o = ~annul_i &
                      (((state_reg == DIV_FREE) & start_i) | div_busy(state_reg));

  assign ready_o  = ready_reg;
  assign result_o = result_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= DIV_FREE;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      dq_reg     <= '0;
      dvsr_reg   <= '0;
      qneg_reg   <= 1'b0;
      rneg_reg   <= 1'b0;
      ready_reg  <= 1'b0;
      result_reg <= '0;
    end else if (annul_i) begin
      state_reg  <= DIV_FREE;
      cnt_reg    <= '0;
      ready_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        DIV_FREE: begin
          ready_reg  <= 1'b0;
          result_reg <= '0;
          if (start_i) begin
            rem_reg  <= '0;
            cnt_reg  <= '0;
            dvsr_reg <= b_mag;
            qneg_reg <= a_neg ^ b_neg;
            rneg_reg <= a_neg;
            if (div_zero) begin
              // Keep the raw dividend: it is returned unchanged as remainder.
              dq_reg    <= dividend_i;
              state_reg <= DIV_DZERO;
            end else begin
              dq_reg    <= a_mag;
              state_reg <= DIV_ON;
            end
          end
        end

        DIV_DZERO: begin
          state_reg  <= DIV_END;
          ready_reg  <= 1'b1;
          result_reg <= {dq_reg, {WIDTH{1'b1}}};
        end

        DIV_ON: begin
          rem_reg <= rem_step;
          dq_reg  <= dq_step;
          if (cnt_reg == CNT_LAST) begin
            cnt_reg    <= '0;
            state_reg  <= DIV_END;
            ready_reg  <= 1'b1;
            result_reg <= {r_fixed, q_fixed};
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DIV_END: begin
          // Operands are never sampled here; a new op is accepted in FREE.
          state_reg  <= DIV_FREE;
          ready_reg  <= 1'b0;
          result_reg <= '0;
        end

        default: begin
          state_reg  <= DIV_FREE;
          ready_reg  <= 1'b0;
          result_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_div_unit
//   Directed scoreboard bench for ex_div_unit. The stimulus process pushes the
//   expected {remainder, quotient} and ready cycle; the monitor pops and
//   compares whenever ready_o is seen.
// ---------------------------------------------------------------------------
module tb_ex_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic [W-1:0]   dividend_i;
  logic [W-1:0]   divisor_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic [63:0] res;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one divide right after a rising edge; that cycle is cycle 0.
  // Start stays high through the END cycle; operands are scrambled after
  // acceptance to show they are not resampled.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [63:0] exp_res, input int lat, input bit keep,
                         input string tag);
    exp_t e;
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    e.cyc = cyc + lat;
    e.res = exp_res;
    sb_q.push_back(e);
    $display("issue %s: a=%h b=%h signed=%0d expect %h at cycle %0d", tag, a, b, sgn, exp_res, e.cyc);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check({tag, "_stall_busy"}, {63'b0, stallreq_o}, 64'd1);
      @(posedge clk); #1;
      if (k == 0) begin
        dividend_i = ~a;
        divisor_i  = ~b;
      end
    end
    @(negedge clk);
    check({tag, "_stall_end"}, {63'b0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    if (!keep) start_i = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (ready_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ready", {63'b0, ready_o}, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          $display("ready at cycle %0d: result %h", cyc, result_o);
          check("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("result", result_o, mon_e.res);
        end
      end else begin
        check("result_idle_zero", result_o, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    annul_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready",  {63'b0, ready_o},    64'd0);
    check("reset_result", result_o,            64'd0);
    check("reset_stall",  {63'b0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Unsigned, signed, divide-by-zero and overflow vectors
    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 1'b0, "u_100_7");
    repeat (3) begin
      @(negedge clk);
      check("idle_stall", {63'b0, stallreq_o}, 64'd0);
    end
    @(posedge clk); #1;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, "s_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, 1'b0, "s_7_m2");
    run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, 33, 1'b0, "s_m100_m7");
    run_div(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 2, 1'b0, "u_dz");
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 2, 1'b0, "s_dz_neg");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, 1'b0, "s_min_m1");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 33, 1'b0, "u_min_max");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33, 1'b0, "u_max_1");

    // Annul at cycle 10 of an ON run: no ready, stall drops
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    $display("issue annul run: a=%h b=%h (no result expected)", dividend_i, divisor_i);
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_stall", {63'b0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("post_annul_stall", {63'b0, stallreq_o}, 64'd0);
    end
    @(posedge clk); #1;
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, 1'b0, "u_after_annul");

    // Reset mid-ON, then back-to-back divides
    start_i    = 1'b1;
    dividend_i = 32'd55;
    divisor_i  = 32'd5;
    $display("issue reset run: a=%h b=%h (no result expected)", dividend_i, divisor_i);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    check("midrst_ready",  {63'b0, ready_o},    64'd0);
    check("midrst_result", result_o,            64'd0);
    check("midrst_stall",  {63'b0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b1, "b2b_9_3");
    run_div(32'd10, 32'd4, 1'b0, {32'd2, 32'd2}, 33, 1'b0, "b2b_10_4");

    // Every pushed expectation must have been consumed
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
